regfile_sb: RTL and testbench

//  Parametrised multi-read, dual-write register file for the 5-stage pipeline.

---
 rtl/regfile_sb.sv | 98 +++++++++
 tb/tb_regfile_sb.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Purpose  : Multi-read, dual-write register file with a per-register pending
//            scoreboard and a registered debug read port. Defining
//            REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wea,
  input  logic [ADDR_W-1:0]        waa,
  input  logic [DATA_W-1:0]        wda,
  input  logic                     web,
  input  logic [ADDR_W-1:0]        wab,
  input  logic [DATA_W-1:0]        wdb,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  input  logic [ADDR_W-1:0]        dbg_sel,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] r_rf [NREG];
  logic [NREG-1:0]   r_pend;
  logic [DATA_W-1:0] r_dbg;

  logic w_wa_en;
  logic w_wb_en;
  logic w_ps_en;

  assign w_wa_en = wea && (waa != '0);
  assign w_wb_en = web && (wab != '0);
  assign w_ps_en = pend_set && (pend_addr != '0);

  // Port B is written last so it wins an address collision; a new issue
  // (pend_set) is applied after the write-clears so the newer producer wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) r_rf[k] <= '0;
      r_pend <= '0;
      r_dbg  <= '0;
    end else begin
      if (w_wa_en) r_rf[waa] <= wda;
      if (w_wb_en) r_rf[wab] <= wdb;
      if (w_wa_en) r_pend[waa] <= 1'b0;
      if (w_wb_en) r_pend[wab] <= 1'b0;
      if (w_ps_en) r_pend[pend_addr] <= 1'b1;
      r_dbg <= (dbg_sel == '0) ? '0 : r_rf[dbg_sel];
    end
  end

  assign dbg_data = r_dbg;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    logic              w_pend;

    assign w_ra = ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd   = '0;
      w_pend = 1'b0;
      if (!reset && (w_ra != '0)) begin
        w_rd   = r_rf[w_ra];
        w_pend = r_pend[w_ra];
`ifdef REGFILE_BYPASS_EN
        if (web && (wab == w_ra)) begin
          w_rd   = wdb;
          w_pend = 1'b0;
        end else if (wea && (waa == w_ra)) begin
          w_rd   = wda;
          w_pend = 1'b0;
        end
`else
        // Writes land at the clock edge; readers see them next cycle.
`endif
      end
    end

    assign rd[i*DATA_W +: DATA_W] = w_rd;
    assign rd_pend[i]             = w_pend;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none

module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra0, ra1;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rd_pend;
  logic        wea, web, pend_set;
  logic [4:0]  waa, wab, pend_addr, dbg_sel;
  logic [31:0] wda, wdb, dbg_data;

  assign ra = {ra1, ra0};

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rd_pend(rd_pend),
    .wea(wea), .waa(waa), .wda(wda), .web(web), .wab(wab), .wdb(wdb),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Signal selectors: 0 rd0, 1 rd1, 2 pend0, 3 pend1, 4 dbg
  typedef struct {
    int          at;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic string sig_name(input int s);
    case (s)
      0: return "rd0";
      1: return "rd1";
      2: return "rd_pend0";
      3: return "rd_pend1";
      default: return "dbg_data";
    endcase
  endfunction

  task automatic push(input int sig, input logic [31:0] exp, input int delay);
    exp_t e;
    e.at  = cyc + delay;
    e.sig = sig;
    e.exp = exp;
    q.push_back(e);
  endtask

  // Monitor: compares every expectation due this cycle at the falling edge.
  always @(negedge clk) begin
    exp_t keep[$];
    logic [31:0] act;
    keep = {};
    foreach (q[k]) begin
      if (q[k].at == cyc) begin
        case (q[k].sig)
          0: act = rd[31:0];
          1: act = rd[63:32];
          2: act = {31'd0, rd_pend[0]};
          3: act = {31'd0, rd_pend[1]};
          default: act = dbg_data;
        endcase
        checks++;
        if (act !== q[k].exp) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h",
                   sig_name(q[k].sig), cyc, act, q[k].exp);
        end
      end else if (q[k].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale expectation for cycle %0d: got none expected %h",
                 sig_name(q[k].sig), q[k].at, q[k].exp);
      end else begin
        keep.push_back(q[k]);
      end
    end
    q = keep;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    wea = 1'b0; web = 1'b0; pend_set = 1'b0;
    waa = '0; wab = '0; pend_addr = '0;
    wda = '0; wdb = '0;
  endtask

  initial begin
    reset = 1'b1; ra0 = '0; ra1 = '0; dbg_sel = '0;
    wea = 1'b0; web = 1'b0; pend_set = 1'b0;
    waa = '0; wab = '0; pend_addr = '0; wda = '0; wdb = '0;
    repeat (2) @(posedge clk);

    // Populate state, then check it is visible
    next_cycle(); reset = 1'b0;
    wea = 1; waa = 5'd1; wda = 32'h0000_0AAA;
    web = 1; wab = 5'd2; wdb = 32'h0000_0BBB;
    pend_set = 1; pend_addr = 5'd4;
    next_cycle(); ra0 = 5'd1; ra1 = 5'd4;
    push(0, 32'h0000_0AAA, 0); push(3, 32'd1, 0);

    // Reset cycle: outputs forced to zero, writes/pend_set ignored
    next_cycle(); reset = 1'b1;
    wea = 1; waa = 5'd3; wda = 32'h55; pend_set = 1; pend_addr = 5'd5;
    ra0 = 5'd1; ra1 = 5'd2; dbg_sel = 5'd1;
    push(0, 32'd0, 0); push(1, 32'd0, 0); push(2, 32'd0, 0); push(3, 32'd0, 0);
    push(4, 32'd0, 1);
    next_cycle(); reset = 1'b0; ra0 = 5'd3; ra1 = 5'd4;
    push(0, 32'd0, 0); push(3, 32'd0, 0); push(4, 32'd0, 1);
    next_cycle(); ra0 = 5'd1; ra1 = 5'd5;
    push(0, 32'd0, 0); push(3, 32'd0, 0);

    // Register 0 never written nor pending
    next_cycle(); wea = 1; waa = 5'd0; wda = 32'hDEAD;
    pend_set = 1; pend_addr = 5'd0; ra0 = 5'd0; ra1 = 5'd0;
    push(0, 32'd0, 0); push(2, 32'd0, 0);
    next_cycle(); ra0 = 5'd0;
    push(0, 32'd0, 0); push(2, 32'd0, 0); push(3, 32'd0, 0);

    // Dual write same address: port B wins
    next_cycle(); wea = 1; waa = 5'd5; wda = 32'h11;
    web = 1; wab = 5'd5; wdb = 32'h22; ra0 = 5'd5;
    push(0, BYP ? 32'h22 : 32'h0, 0);
    next_cycle(); ra0 = 5'd5;
    push(0, 32'h22, 0);

    // Pending then resolving write
    next_cycle(); pend_set = 1; pend_addr = 5'd7; ra0 = 5'd7;
    push(2, 32'd0, 0);
    next_cycle(); ra0 = 5'd7;
    push(2, 32'd1, 0); push(0, 32'd0, 0);
    next_cycle(); wea = 1; waa = 5'd7; wda = 32'hA5; ra0 = 5'd7;
    push(0, BYP ? 32'hA5 : 32'h0, 0); push(2, BYP ? 32'd0 : 32'd1, 0);
    next_cycle(); ra0 = 5'd7;
    push(0, 32'hA5, 0); push(2, 32'd0, 0);

    // Same-edge pend_set and write: set wins, data stored
    next_cycle(); pend_set = 1; pend_addr = 5'd9;
    wea = 1; waa = 5'd9; wda = 32'h99; ra1 = 5'd9;
    push(1, BYP ? 32'h99 : 32'h0, 0); push(3, 32'd0, 0);
    next_cycle(); ra1 = 5'd9;
    push(1, 32'h99, 0); push(3, 32'd1, 0);

    // Debug port: pre-write contents, one-cycle latency
    next_cycle(); wea = 1; waa = 5'd3; wda = 32'h1234; dbg_sel = 5'd3;
    push(4, 32'h0, 1);
    next_cycle(); dbg_sel = 5'd3;
    push(4, 32'h1234, 1);
    next_cycle(); web = 1; wab = 5'd3; wdb = 32'hBEEF; ra0 = 5'd3; ra1 = 5'd5;
    push(0, BYP ? 32'hBEEF : 32'h1234, 0); push(1, 32'h22, 0);
    push(4, 32'h1234, 1);
    next_cycle(); ra0 = 5'd3;
    push(0, 32'hBEEF, 0); push(4, 32'hBEEF, 1);

    for (int w = 0; w < 5 && q.size() > 0; w++) next_cycle();
    foreach (q[k]) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got none expected %h", sig_name(q[k].sig), q[k].exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
